// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the FIFO read-side stream adapter.
package fifo_pkg;
  localparam int WIDTH_DEF      = 8;
  localparam int SKID_DEPTH_DEF = 3;
  localparam int BEAT_CNT_W     = 32;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular skid buffer holding popped FIFO words until the sink accepts them; head visible same cycle.
// Sink stalls simply hold the head; flush clears occupancy and pointers at the next edge and beats a pop.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int Width      = WIDTH_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              wr_vld,
  input  logic [Width-1:0]                  wr_dat,
  output logic                              rd_vld,
  input  logic                              rd_rdy,
  output logic [Width-1:0]                  rd_dat,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   occ
);
  localparam int PTR_W = ptr_w(SKID_DEPTH);

  logic [Width-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_vld = (occ != '0);
  assign rd_dat = mem[rd_ptr];
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (pop) rd_ptr <= wrap_inc(rd_ptr);
      case ({wr_vld, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port driver: rd_en to m_valid is 2 cycles, buffered in a skid buffer; m_ready may stall anytime
// because rd_en only reserves free slots (never looks at m_ready). FIFO_RD_STREAM_BEAT_CNT_EN adds beat_cnt.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int Width      = WIDTH_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [Width-1:0]      d_out,
  output logic                  rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [Width-1:0]      m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  ,
  output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);
  localparam int               OCC_W   = $clog2(SKID_DEPTH + 1);
  localparam logic [OCC_W:0]   DEPTH_V = (OCC_W + 1)'(SKID_DEPTH);

  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   inflight;
  logic             pending;
  logic             drop;
  logic             capture;

  // Slots already committed: buffered words plus the one on the FIFO read bus.
  assign inflight = {1'b0, occ} + {{OCC_W{1'b0}}, pending};
  // rst gate drops the pop request the instant reset asserts.
  assign rd_en    = rst && !empty && !flush && (inflight < DEPTH_V);
  assign capture  = pending && !drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      drop    <= 1'b0;
    end else begin
      pending <= rd_en;
      drop    <= flush ? pending : 1'b0;
    end
  end

  fifo_rd_skid_buf #(
    .Width      (Width),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .wr_vld (capture),
    .wr_dat (d_out),
    .rd_vld (m_valid),
    .rd_rdy (m_ready),
    .rd_dat (m_data),
    .occ    (occ)
  );

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    beat_cnt <= '0;
    else if (m_valid && m_ready) beat_cnt <= beat_cnt + 1'b1;
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) inflight <= DEPTH_V);
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model drives the read port, scoreboard predicts the stream.
module tb_fifo_rd_stream;
  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         empty;
  logic [W-1:0] d_out;
  logic         rd_en;
  logic         flush;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready;
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  logic [31:0]  beat_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream #(.Width(W), .SKID_DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .empty   (empty),
    .d_out   (d_out),
    .rd_en   (rd_en),
    .flush   (flush),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready)
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    ,
    .beat_cnt(beat_cnt)
`endif
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accepted = 0;

  logic [W-1:0] fifo_q[$];   // words sitting in the FIFO
  logic [W-1:0] exp_dat[$];  // words popped but not yet delivered
  int           exp_cyc[$];  // cycle in which each was popped
  logic [W-1:0] got_q[$];    // words accepted by the sink
  logic [W-1:0] next_dout;
  logic         dout_load = 1'b0;

  logic         obs_rd, obs_vld, exp_rd, exp_vld;
  logic [W-1:0] obs_dat, exp_d;

  // One cycle: inputs change at negedge, outputs sampled 1 time unit later.
  // A popped word shows on the stream two cycles after its pop; rd_en is
  // allowed only while fewer than D popped words remain undelivered.
  task automatic step(input logic fl, input logic rdy);
    flush   = fl;
    m_ready = rdy;
    empty   = (fifo_q.size() == 0);
    if (dout_load) d_out = next_dout;
    dout_load = 1'b0;
    #1;
    obs_rd  = rd_en;
    obs_vld = m_valid;
    obs_dat = m_data;
    exp_rd  = !empty && !fl && (exp_dat.size() < D);
    exp_vld = (exp_dat.size() > 0) && (exp_cyc[0] <= cyc - 2);
    exp_d   = exp_vld ? exp_dat[0] : '0;
    if (exp_vld && rdy) accepted++;
    if (fl) begin
      exp_dat.delete();
      exp_cyc.delete();
    end else if (exp_vld && rdy) begin
      void'(exp_dat.pop_front());
      void'(exp_cyc.pop_front());
    end
    if (obs_vld && rdy && !fl) got_q.push_back(obs_dat);
    if (obs_rd && fifo_q.size() > 0) begin
      next_dout = fifo_q.pop_front();
      dout_load = 1'b1;
      exp_dat.push_back(next_dout);
      exp_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_dat.delete();
    exp_cyc.delete();
    got_q.delete();
    dout_load = 1'b0;
    accepted  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; m_ready = 1'b0; empty = 1'b1; d_out = '0;
    repeat (2) @(negedge clk);
    empty = 1'b0;
    #1;
    n_tests++;
    if (rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state rd_en=%b m_valid=%b m_data=%h want 0 0 00", rd_en, m_valid, m_data);
    end
    @(negedge clk);
    empty = 1'b1;
    rst   = 1'b1;
    #1;
    n_tests++;
    if (rd_en !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_release rd_en=%b m_valid=%b want 0 0", rd_en, m_valid);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_preload();
    logic [W-1:0] want [3];
    int start, rd_cnt, first_vld;
    want = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) fifo_q.push_back(want[i]);
    got_q.delete();
    start = cyc; rd_cnt = 0; first_vld = -1;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1);
      n_tests++;
      if (obs_rd !== exp_rd || obs_vld !== exp_vld || (exp_vld && obs_dat !== exp_d)) begin
        n_fail++;
        $display("FAIL preload cyc=%0d rd_en=%b exp %b m_valid=%b exp %b m_data=%h exp %h",
                 cyc - 1, obs_rd, exp_rd, obs_vld, exp_vld, obs_dat, exp_d);
      end
      if (obs_rd) rd_cnt++;
      if (obs_vld && first_vld < 0) first_vld = cyc - 1 - start;
    end
    n_tests++;
    if (rd_cnt != 3 || first_vld != 2) begin
      n_fail++;
      $display("FAIL preload_latency rd_en_cnt=%0d first_valid=%0d want 3 2", rd_cnt, first_vld);
    end
    n_tests++;
    if (got_q.size() != 3 || got_q[0] !== want[0] || got_q[1] !== want[1] || got_q[2] !== want[2]) begin
      n_fail++;
      $display("FAIL preload_data got %0d words first=%h want 3 words 11 22 33", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] words[$];
    int rd_cnt, first_acc, last_acc;
    for (int i = 0; i < 10; i++) words.push_back(W'($urandom_range(0, 255)));
    foreach (words[i]) fifo_q.push_back(words[i]);
    got_q.delete();
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      n_tests++;
      if (obs_rd !== exp_rd || obs_vld !== exp_vld || (exp_vld && obs_dat !== exp_d)) begin
        n_fail++;
        $display("FAIL stall cyc=%0d rd_en=%b exp %b m_valid=%b exp %b m_data=%h exp %h",
                 cyc - 1, obs_rd, exp_rd, obs_vld, exp_vld, obs_dat, exp_d);
      end
      if (obs_rd) rd_cnt++;
    end
    n_tests++;
    if (rd_cnt != 3 || obs_dat !== words[0]) begin
      n_fail++;
      $display("FAIL stall_hold pops=%0d m_data=%h want 3 %h", rd_cnt, obs_dat, words[0]);
    end
    first_acc = -1; last_acc = -1;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b1);
      n_tests++;
      if (obs_rd !== exp_rd || obs_vld !== exp_vld || (exp_vld && obs_dat !== exp_d)) begin
        n_fail++;
        $display("FAIL stall_release cyc=%0d rd_en=%b exp %b m_valid=%b exp %b m_data=%h exp %h",
                 cyc - 1, obs_rd, exp_rd, obs_vld, exp_vld, obs_dat, exp_d);
      end
      if (obs_vld) begin
        if (first_acc < 0) first_acc = cyc - 1;
        last_acc = cyc - 1;
      end
    end
    n_tests++;
    if (got_q != words || last_acc - first_acc != 9) begin
      n_fail++;
      $display("FAIL stall_stream words=%0d span=%0d want 10 9", got_q.size(), last_acc - first_acc);
    end
  endtask

  task automatic test_toggle();
    logic [W-1:0] words[$];
    for (int i = 0; i < 8; i++) words.push_back(W'($urandom_range(0, 255)));
    foreach (words[i]) fifo_q.push_back(words[i]);
    got_q.delete();
    for (int i = 0; i < 24; i++) begin
      step(1'b0, (i % 2) == 0);
      n_tests++;
      if (obs_rd !== exp_rd || obs_vld !== exp_vld || (exp_vld && obs_dat !== exp_d)) begin
        n_fail++;
        $display("FAIL toggle cyc=%0d rd_en=%b exp %b m_valid=%b exp %b m_data=%h exp %h",
                 cyc - 1, obs_rd, exp_rd, obs_vld, exp_vld, obs_dat, exp_d);
      end
    end
    n_tests++;
    if (got_q != words) begin
      n_fail++;
      $display("FAIL toggle_order got %0d words want 8 in order", got_q.size());
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] words[$];
    for (int i = 0; i < 4; i++) words.push_back(W'($urandom_range(0, 255)));
    foreach (words[i]) fifo_q.push_back(words[i]);
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      step(i == 3, i >= 3);
      n_tests++;
      if (obs_rd !== exp_rd || obs_vld !== exp_vld || (exp_vld && obs_dat !== exp_d)) begin
        n_fail++;
        $display("FAIL flush cyc=%0d rd_en=%b exp %b m_valid=%b exp %b m_data=%h exp %h",
                 cyc - 1, obs_rd, exp_rd, obs_vld, exp_vld, obs_dat, exp_d);
      end
      if (i == 4 && obs_vld !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL flush_valid m_valid=%b want 0", obs_vld);
      end
    end
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== words[3]) begin
      n_fail++;
      $display("FAIL flush_next got %0d words first=%h want 1 word %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 8'h00, words[3]);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] fresh[$];
    for (int i = 0; i < 2; i++) fifo_q.push_back(W'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      n_tests++;
      if (obs_rd !== exp_rd || obs_vld !== exp_vld || (exp_vld && obs_dat !== exp_d)) begin
        n_fail++;
        $display("FAIL areset_fill cyc=%0d rd_en=%b exp %b m_valid=%b exp %b m_data=%h exp %h",
                 cyc - 1, obs_rd, exp_rd, obs_vld, exp_vld, obs_dat, exp_d);
      end
    end
    empty = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (rd_en !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_outputs rd_en=%b m_valid=%b want 0 0", rd_en, m_valid);
    end
    model_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) fresh.push_back(W'($urandom_range(0, 255)));
    foreach (fresh[i]) fifo_q.push_back(fresh[i]);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      n_tests++;
      if (obs_rd !== exp_rd || obs_vld !== exp_vld || (exp_vld && obs_dat !== exp_d)) begin
        n_fail++;
        $display("FAIL areset_after cyc=%0d rd_en=%b exp %b m_valid=%b exp %b m_data=%h exp %h",
                 cyc - 1, obs_rd, exp_rd, obs_vld, exp_vld, obs_dat, exp_d);
      end
    end
    n_tests++;
    if (got_q != fresh) begin
      n_fail++;
      $display("FAIL areset_stale got %0d words want 2 fresh words", got_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) fifo_q.push_back(W'($urandom));
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
      n_tests++;
      if (obs_rd !== exp_rd || obs_vld !== exp_vld || (exp_vld && obs_dat !== exp_d)) begin
        n_fail++;
        $display("FAIL random cyc=%0d rd_en=%b exp %b m_valid=%b exp %b m_data=%h exp %h",
                 cyc - 1, obs_rd, exp_rd, obs_vld, exp_vld, obs_dat, exp_d);
      end
    end
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    n_tests++;
    if (beat_cnt !== 32'(accepted)) begin
      n_fail++;
      $display("FAIL random_beat_cnt beat_cnt=%0d want %0d", beat_cnt, accepted);
    end
`endif
  endtask

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  task automatic test_beat_cnt();
    #2;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) fifo_q.push_back(W'($urandom_range(0, 255)));
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
    n_tests++;
    if (beat_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL beat_cnt beat_cnt=%0d want 5", beat_cnt);
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    n_tests++;
    if (beat_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL beat_cnt_flush beat_cnt=%0d want 5", beat_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_preload();
    test_stall();
    test_toggle();
    test_flush();
    test_async_reset();
    test_random();
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    test_beat_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
